// File: rtl/sequencer.sv
// Four-state Moore control sequencer driven by a single input A.
// The Gray-coded state register is the output: {Q1,Q2} = state.
module sequencer (
  input  logic clk,
  input  logic n_rst,
  input  logic A,
  output logic Q1,
  output logic Q2
);

  typedef enum logic [1:0] {
    AA = 2'b00,
    AB = 2'b01,
    AC = 2'b11,
    AD = 2'b10
  } state_t;

  state_t state;
  state_t next_state;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= AA;
    end else begin
      state <= next_state;
    end
  end

  // AC always falls back to AA; AD holds while A stays high.
  always_comb begin
    next_state = AA;
    case (state)
      AA:      next_state = A ? AB : AA;
      AB:      next_state = A ? AD : AC;
      AC:      next_state = AA;
      AD:      next_state = A ? AD : AA;
      default: next_state = AA;
    endcase
  end

  assign Q1 = state[1];
  assign Q2 = state[0];

endmodule

// File: tb/tb_sequencer.sv
// Bench for sequencer: directed paths from the test plan followed by random
// A / reset stimulus, scored against a table-driven model of the state graph.
module tb_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic a = 1'b0;
  logic q1;
  logic q2;

  always #5 clk = ~clk;

  sequencer dut (
    .clk   (clk),
    .n_rst (n_rst),
    .A     (a),
    .Q1    (q1),
    .Q2    (q2)
  );

  // ---------------- reference model ----------------
  // States by ordinal: 0=AA 1=AB 2=AC 3=AD. nxt_tab[state][A].
  int         nxt_tab [4][2] = '{'{0, 1}, '{2, 3}, '{0, 0}, '{0, 3}};
  logic [1:0] code_tab[4]    = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         model_st = 0;
  bit         model_valid = 1'b0;

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: Q1Q2=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock per call. Inputs change at the falling edge; outputs are first
  // checked to be unaffected by the new inputs, then checked after the edge.
  // glitch pulses n_rst low mid-cycle but releases it before the edge.
  task automatic drive_step(input logic a_in, input logic rst_in, input bit glitch,
                            input string tag);
    logic [1:0] exp;
    @(negedge clk);
    a = a_in;
    n_rst = glitch ? 1'b0 : rst_in;
    #1;
    if (model_valid) check({tag, "_hold"}, {q1, q2}, code_tab[model_st]);
    #1;
    n_rst = rst_in;
    if (!rst_in) begin
      model_st = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      model_st = nxt_tab[model_st][int'(a_in)];
    end
    if (model_valid) exp_q.push_back(code_tab[model_st]);
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check(tag, {q1, q2}, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held while A toggles.
    drive_step(1'b0, 1'b0, 1'b0, "rst0");
    drive_step(1'b1, 1'b0, 1'b0, "rst_a1");
    drive_step(1'b0, 1'b0, 1'b0, "rst_a0");
    drive_step(1'b1, 1'b0, 1'b0, "rst_a1b");

    // Idle hold in AA.
    for (int i = 0; i < 3; i++) drive_step(1'b0, 1'b1, 1'b0, "idle");

    // Short path AA->AB->AC->AA (A ignored in AC).
    drive_step(1'b1, 1'b1, 1'b0, "short_ab");
    drive_step(1'b0, 1'b1, 1'b0, "short_ac");
    drive_step(1'b1, 1'b1, 1'b0, "short_aa");

    // Long path AA->AB->AD->AD->AA.
    drive_step(1'b1, 1'b1, 1'b0, "long_ab");
    drive_step(1'b1, 1'b1, 1'b0, "long_ad");
    drive_step(1'b1, 1'b1, 1'b0, "long_ad2");
    drive_step(1'b0, 1'b1, 1'b0, "long_aa");

    // AD dwell then exit.
    drive_step(1'b1, 1'b1, 1'b0, "dwell_ab");
    drive_step(1'b1, 1'b1, 1'b0, "dwell_ad");
    for (int i = 0; i < 5; i++) drive_step(1'b1, 1'b1, 1'b0, "dwell");
    drive_step(1'b0, 1'b1, 1'b0, "dwell_exit");

    // Reset from AD with A=1, then release.
    drive_step(1'b1, 1'b1, 1'b0, "mid_ab");
    drive_step(1'b1, 1'b1, 1'b0, "mid_ad");
    drive_step(1'b1, 1'b0, 1'b0, "mid_rst");
    drive_step(1'b1, 1'b1, 1'b0, "mid_release");

    // A reset pulse that ends before the edge must not be seen.
    drive_step(1'b1, 1'b1, 1'b1, "glitch_ad");
    drive_step(1'b1, 1'b1, 1'b1, "glitch_ad2");

    // Reset from AC.
    drive_step(1'b0, 1'b1, 1'b0, "rac_aa");
    drive_step(1'b1, 1'b1, 1'b0, "rac_ab");
    drive_step(1'b0, 1'b1, 1'b0, "rac_ac");
    drive_step(1'b1, 1'b0, 1'b0, "rac_rst");

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      logic ra;
      logic rr;
      bit   rg;
      ra = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 15) != 0);
      rg = ($urandom_range(0, 15) == 0);
      drive_step(ra, rr, rg, "rand");
    end

    if (exp_q.size() != 0) check("queue_drain", 2'(exp_q.size()), 2'b00);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
